// File: rtl/exp_disp_pkg.sv
// Shared definitions for the exponent-result display path.
// Holds the converter state encoding, default widths and ASCII constants,
// plus a helper that renders one BCD digit as its ASCII character.
package exp_disp_pkg;

    localparam int RES_W_DEF  = 16;
    localparam int DIGITS_DEF = 5;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // One BCD digit (0..9) to its printable character '0'..'9'.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/exp_result_bcd_if.sv
// Bundle of the handshake and data signals between the exponent FSMD / LCD
// controller side (master) and the binary-to-BCD converter (slave).
//   done_i/result_i : result hand-off from the exponent FSMD
//   ack_i           : LCD controller consumed the digits
//   busy_o/valid_o  : converter status
//   bcd_o/ascii_o   : converted digits
//   overrun_o       : a new result was dropped
interface exp_result_bcd_if
    import exp_disp_pkg::*;
#(
    parameter int RES_W  = RES_W_DEF,
    parameter int DIGITS = DIGITS_DEF
);
    logic                  done_i;
    logic [RES_W-1:0]      result_i;
    logic                  ack_i;
    logic                  busy_o;
    logic                  valid_o;
    logic [4*DIGITS-1:0]   bcd_o;
    logic [8*DIGITS-1:0]   ascii_o;
    logic                  overrun_o;

    modport master (
        output done_i, result_i, ack_i,
        input  busy_o, valid_o, bcd_o, ascii_o, overrun_o
    );

    modport slave (
        input  done_i, result_i, ack_i,
        output busy_o, valid_o, bcd_o, ascii_o, overrun_o
    );
endinterface

// File: rtl/exp_result_bcd_nibble_adj.sv
// Double-dabble correction for a single BCD nibble: values 5..15 get 3 added
// so that the following left shift carries correctly into the next digit.
//   nib_i : scratch nibble before the shift
//   nib_o : corrected nibble
module bcd_nibble_adj (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);
    // Add-3 correction when the digit would overflow after doubling.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end else begin
            nib_o = nib_i;
        end
    end
endmodule

// File: rtl/exp_result_bcd.sv
// Converts the exponent FSMD result to packed BCD and blank-padded ASCII
// for the LCD controller, one double-dabble shift per clock.
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   done_i    : level done flag; a rising edge starts a conversion
//   result_i  : binary result, sampled on the rising edge of done_i
//   ack_i     : LCD controller consumed the digits (only honoured in HOLD)
//   busy_o    : conversion in progress
//   valid_o   : bcd_o/ascii_o hold a finished conversion awaiting ack
//   bcd_o     : packed BCD, most-significant digit in the top nibble
//   ascii_o   : ASCII digits with leading zeros blanked, MS char in top byte
//   overrun_o : one-cycle pulse when a done_i rise had to be dropped
module exp_result_bcd
    import exp_disp_pkg::*;
#(
    parameter int RES_W  = RES_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done_i,
    input  logic [RES_W-1:0]    result_i,
    input  logic                ack_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [4*DIGITS-1:0] bcd_o,
    output logic [8*DIGITS-1:0] ascii_o,
    output logic                overrun_o
);
    localparam int BW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(RES_W + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(RES_W - 1);

    state_t              state_q, state_d;
    logic                done_q;
    logic [RES_W-1:0]    bin_q, bin_d;
    logic [BW-1:0]       scr_q, scr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [8*DIGITS-1:0] ascii_q, ascii_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    logic                rise_s;
    logic [BW-1:0]       adj_s;
    logic [BW+RES_W-1:0] cat_s;
    logic [BW+RES_W-1:0] sh_s;
    logic [BW-1:0]       new_bcd_s;
    logic [8*DIGITS-1:0] asc_s;

    assign rise_s = done_i & ~done_q;

    // Correct every scratch digit before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib_i (scr_q[4*g +: 4]),
            .nib_o (adj_s[4*g +: 4])
        );
    end

    // {scratch, binary} moves left one bit; the binary MSB enters scratch.
    assign cat_s     = {adj_s, bin_q};
    assign sh_s      = cat_s << 1'b1;
    assign new_bcd_s = sh_s[BW+RES_W-1:RES_W];

    // ASCII rendering of the digits produced by the current shift; leading
    // zeros blank out, the least-significant digit always prints.
    always_comb begin
        logic       seen;
        logic [3:0] nib;
        asc_s = {DIGITS{ASCII_SPACE}};
        seen  = 1'b0;
        nib   = 4'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = new_bcd_s[4*i +: 4];
            if ((nib != 4'd0) || (i == 0)) begin
                seen = 1'b1;
            end else begin
                seen = seen;
            end
            if (seen) begin
                asc_s[8*i +: 8] = digit_to_ascii(nib);
            end else begin
                asc_s[8*i +: 8] = ASCII_SPACE;
            end
        end
    end

    // Next-state and datapath control for IDLE / SHIFT / HOLD.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scr_d     = scr_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ascii_d   = ascii_q;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    bin_d   = result_i;
                    scr_d   = {BW{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                bin_d     = sh_s[RES_W-1:0];
                scr_d     = new_bcd_s;
                cnt_d     = cnt_q + CNT_W'(1'b1);
                overrun_d = rise_s;
                if (cnt_q == LAST_SHIFT) begin
                    bcd_d   = new_bcd_s;
                    ascii_d = asc_s;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (ack_i) begin
                    // A rise coinciding with the ack is accepted, not dropped.
                    if (rise_s) begin
                        bin_d   = result_i;
                        scr_d   = {BW{1'b0}};
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    overrun_d = rise_s;
                    state_d   = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_HOLD);
        busy_d  = (state_d == ST_SHIFT);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            bin_q     <= {RES_W{1'b0}};
            scr_q     <= {BW{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            bcd_q     <= {BW{1'b0}};
            ascii_q   <= {DIGITS{ASCII_SPACE}};
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_i;
            bin_q     <= bin_d;
            scr_q     <= scr_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ascii_q   <= ascii_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy_o    = busy_q;
    assign valid_o   = valid_q;
    assign bcd_o     = bcd_q;
    assign ascii_o   = ascii_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_exp_result_bcd.sv
// Directed plus random checks of exp_result_bcd against a decimal model.
module tb_exp_result_bcd;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    exp_result_bcd_if #(.RES_W(16), .DIGITS(5)) bus ();

    exp_result_bcd #(.RES_W(16), .DIGITS(5)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .done_i    (bus.done_i),
        .result_i  (bus.result_i),
        .ack_i     (bus.ack_i),
        .busy_o    (bus.busy_o),
        .valid_o   (bus.valid_o),
        .bcd_o     (bus.bcd_o),
        .ascii_o   (bus.ascii_o),
        .overrun_o (bus.overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits by plain division.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = 20'd0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: right-justified, space-padded decimal text.
    function automatic logic [39:0] ref_ascii(input int unsigned v);
        string s;
        logic [39:0] r;
        s = $sformatf("%5d", v);
        r = 40'd0;
        for (int i = 0; i < 5; i++) begin
            r[8*(4-i) +: 8] = s[i];
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input int unsigned v, input string tag);
        chk(64'(bus.bcd_o), 64'(ref_bcd(v)), {tag, " bcd"});
        chk(64'(bus.ascii_o), 64'(ref_ascii(v)), {tag, " ascii"});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk(64'(bus.valid_o), 64'd0, {tag, " valid"});
        chk(64'(bus.busy_o), 64'd0, {tag, " busy"});
        chk(64'(bus.overrun_o), 64'd0, {tag, " overrun"});
        chk(64'(bus.bcd_o), 64'd0, {tag, " bcd"});
        chk(64'(bus.ascii_o), 64'h2020202020, {tag, " ascii"});
    endtask

    task automatic start_conv(input logic [15:0] v);
        bus.result_i = v;
        bus.done_i   = 1'b1;
        step();
        bus.done_i   = 1'b0;
    endtask

    // Called just after the capture edge; optionally injects a second rise.
    task automatic wait_done(input int unsigned v, input int inject_at,
                             input logic [15:0] inj_val, input string tag);
        int n  = 0;
        int nb = 0;
        int no = 0;
        while (bus.valid_o !== 1'b1 && n < 40) begin
            if (n == inject_at) begin
                bus.result_i = inj_val;
                bus.done_i   = 1'b1;
            end
            if (bus.busy_o === 1'b1) nb++;
            if (bus.overrun_o === 1'b1) no++;
            step();
            n++;
        end
        if (bus.overrun_o === 1'b1) no++;
        chk(64'(n), 64'd16, {tag, " latency"});
        chk(64'(nb), 64'd16, {tag, " busy_cycles"});
        chk(64'(no), (inject_at >= 0) ? 64'd1 : 64'd0, {tag, " overrun_count"});
        chk(64'(bus.busy_o), 64'd0, {tag, " busy_end"});
        chk_result(v, tag);
    endtask

    task automatic do_ack(input string tag);
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        chk(64'(bus.valid_o), 64'd0, {tag, " valid_after_ack"});
        chk(64'(bus.busy_o), 64'd0, {tag, " busy_after_ack"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned rv;
        rst_n        = 1'b0;
        bus.done_i   = 1'b0;
        bus.result_i = 16'd0;
        bus.ack_i    = 1'b0;

        // Reset state
        step();
        step();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        step();
        chk(64'(bus.valid_o), 64'd0, "idle valid");

        // 81
        start_conv(16'd81);
        wait_done(81, -1, 16'd0, "v81");
        do_ack("v81");

        // Boundary values
        start_conv(16'd0);
        wait_done(0, -1, 16'd0, "v0");
        do_ack("v0");
        start_conv(16'd32768);
        wait_done(32768, -1, 16'd0, "v32768");
        do_ack("v32768");
        start_conv(16'd65535);
        wait_done(65535, -1, 16'd0, "v65535");
        do_ack("v65535");

        // Random values
        for (int k = 0; k < 8; k++) begin
            rv = $urandom_range(65535, 0);
            start_conv(16'(rv));
            wait_done(rv, -1, 16'd0, $sformatf("rand%0d", k));
            do_ack($sformatf("rand%0d", k));
        end

        // Hold without ack, then ack; digits persist after ack
        start_conv(16'd16807);
        wait_done(16807, -1, 16'd0, "v16807");
        for (int k = 0; k < 10; k++) begin
            step();
            chk(64'(bus.valid_o), 64'd1, "hold valid");
            chk_result(16807, "hold");
        end
        do_ack("v16807");
        step();
        chk_result(16807, "post_ack");
        // ack outside HOLD has no effect
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        chk(64'(bus.valid_o), 64'd0, "idle_ack valid");
        chk(64'(bus.busy_o), 64'd0, "idle_ack busy");

        // Rise during SHIFT is dropped with an overrun pulse
        start_conv(16'd3125);
        wait_done(3125, 4, 16'd999, "v3125_ovr");
        bus.done_i = 1'b0;
        step();
        do_ack("v3125_ovr");

        // Reset in mid-shift, done held high through release
        start_conv(16'd14641);
        for (int k = 0; k < 8; k++) step();
        bus.done_i   = 1'b1;
        bus.result_i = 16'd14641;
        rst_n        = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        step();
        step();
        chk_reset_vals("in_rst");
        rst_n = 1'b1;
        step();
        chk(64'(bus.busy_o), 64'd1, "post_rst busy");
        wait_done(14641, -1, 16'd0, "v14641");
        bus.done_i = 1'b0;
        step();
        do_ack("v14641");

        // ack and a new rise in the same HOLD cycle
        start_conv(16'd2197);
        wait_done(2197, -1, 16'd0, "v2197");
        bus.ack_i    = 1'b1;
        bus.done_i   = 1'b1;
        bus.result_i = 16'd6561;
        step();
        bus.ack_i  = 1'b0;
        bus.done_i = 1'b0;
        chk(64'(bus.valid_o), 64'd0, "ackrise valid");
        chk(64'(bus.busy_o), 64'd1, "ackrise busy");
        chk(64'(bus.overrun_o), 64'd0, "ackrise overrun");
        wait_done(6561, -1, 16'd0, "v6561");
        do_ack("v6561");
        step();
        chk_result(6561, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
